uart_write: RTL and testbench

Byte-serial UART transmitter, 8N1, LSB first, with a small input FIFO. It is the transmit half of the board UART and pairs with the existing receiver on the same 115200 baud link. Upstream logic pushes bytes over a valid/ready handshake. The block frames and shifts them out on `tx_pin` back-to-back, and pulses `done` once per completed frame.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_fifo.sv | 71 +++++++
 rtl/uart_write.sv | 157 +++++++++++++++
 tb/tb_uart_write.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame width
// and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; pushes while full and pops
// while empty are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           push_i,
    input  logic [DATA_BITS-1:0]           data_i,
    input  logic                           pop_i,
    output logic [DATA_BITS-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 push_s;
    logic                 pop_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Byte storage; cleared on reset so discarded entries never reappear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_write.sv
// UART 8N1 transmitter, LSB first: a byte FIFO feeds a start/data/stop
// framing FSM that sends queued bytes back-to-back.
module uart_write
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clock_50mhz,
    input  logic                               reset_n,
    input  logic [DATA_BITS-1:0]               wr_data,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    output logic                               tx_pin,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CPB    = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int BAUD_W = $clog2(CPB);
    localparam int BIT_W  = $clog2(DATA_BITS);

    if (CPB < 2) begin : g_bad_baud
        $error("uart_write: CLK_FREQ / BAUD must be at least 2");
    end

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 baud_last_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_head_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock_50mhz),
        .rst_n_i (reset_n),
        .push_i  (wr_valid),
        .data_i  (wr_data),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .count_o (fifo_count),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign baud_last_s = (baud_q == BAUD_W'(CPB - 1));
    assign wr_ready    = !fifo_full_s;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty_s;
    assign tx_pin      = tx_q;
    assign done        = done_q;

    // State and datapath registers; the line is forced idle-high by reset.
    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            baud_q  <= BAUD_W'(0);
            bit_q   <= BIT_W'(0);
            shift_q <= {DATA_BITS{1'b0}};
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state: one baud period per line bit, reloading from the FIFO
    // straight out of the stop bit so frames run without a gap.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_head_s;
                    baud_d  = BAUD_W'(0);
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = BAUD_W'(0);
                    bit_d   = BIT_W'(0);
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d  = BAUD_W'(0);
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = BIT_W'(0);
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = BAUD_W'(0);
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_head_s;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = BAUD_W'(0);
                bit_d   = BIT_W'(0);
            end
        endcase
    end

    // Outputs are computed from the next state so the registered copies
    // line up with the state they describe.
    always_comb begin
        tx_d   = 1'b1;
        done_d = (state_d == ST_STOP) && (baud_d == BAUD_W'(CPB - 1));
        case (state_d)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_write.sv
// Self-checking bench for uart_write: a per-cycle waveform model plus
// directed frame, FIFO and reset scenarios at the default 434 clocks/bit.
module tb_uart_write;

    localparam int CPB   = 434;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       tx_pin;
    logic       busy;
    logic       done;
    logic [2:0] fifo_count;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     done_cnt = 0;
    bit     chk_en   = 1'b0;
    longint cyc      = 0;

    logic [7:0] m_fifo[$];
    bit         m_wave[$];

    uart_write #(
        .CLK_FREQ   (50_000_000),
        .BAUD       (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock_50mhz (clk),
        .reset_n     (reset_n),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .tx_pin      (tx_pin),
        .busy        (busy),
        .done        (done),
        .fifo_count  (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue plus the expected line level for every
    // remaining cycle of the frame in flight.
    initial begin : model
        logic [7:0] b;
        bit         push;
        forever begin
            @(posedge clk or negedge reset_n);
            if (reset_n !== 1'b1) begin
                m_fifo.delete();
                m_wave.delete();
            end else begin
                cyc++;
                push = (wr_valid === 1'b1) && (m_fifo.size() != DEPTH);
                if (m_wave.size() != 0) void'(m_wave.pop_front());
                if (m_wave.size() == 0 && m_fifo.size() != 0) begin
                    b = m_fifo.pop_front();
                    for (int s = 0; s < 10; s++)
                        for (int k = 0; k < CPB; k++)
                            m_wave.push_back((s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1]);
                end
                if (push) m_fifo.push_back(wr_data);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("tx_pin", 32'(tx_pin), (m_wave.size() != 0) ? 32'(m_wave[0]) : 32'd1);
                chk("done", 32'(done), 32'(m_wave.size() == 1));
                chk("busy", 32'(busy), 32'((m_wave.size() != 0) || (m_fifo.size() != 0)));
                chk("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
                chk("wr_ready", 32'(wr_ready), 32'(m_fifo.size() != DEPTH));
                if (done === 1'b1) done_cnt++;
            end
        end
    end

    initial begin : watchdog
        #(64'd10 * 64'd100000);
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        wr_data  = b;
        wr_valid = 1'b1;
        while (wr_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_seen", 32'(wr_ready === 1'b1), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Called at the negedge of frame cycle 1; returns at cycle FRAME+1.
    task automatic frame_check(input string tag, input logic [9:0] exp_lv, output logic [9:0] lv);
        int dseen;
        int dat;
        lv    = 10'd0;
        dseen = 0;
        dat   = 0;
        chk({tag, "_start_edge"}, 32'(tx_pin), 32'd0);
        for (int c = 1; c <= FRAME + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= FRAME && ((c - 1) % CPB) == CPB / 2) lv[(c - 1) / CPB] = tx_pin;
            if (c <= FRAME && done === 1'b1) begin
                dseen++;
                dat = c;
            end
            if (c == FRAME + 1) chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        end
        chk({tag, "_levels"}, 32'(lv), 32'(exp_lv));
        chk({tag, "_done_pulses"}, 32'(dseen), 32'd1);
        chk({tag, "_done_cycle"}, 32'(dat), 32'(FRAME));
    endtask

    task automatic recv_byte(output logic [7:0] b, output longint t0);
        int n;
        n = 0;
        b = 8'h00;
        while (tx_pin !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        chk("rx_start_found", 32'(tx_pin === 1'b0), 32'd1);
        repeat (CPB / 2) @(negedge clk);
        chk("rx_start_mid", 32'(tx_pin), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx_pin;
        end
        repeat (CPB) @(negedge clk);
        chk("rx_stop_mid", 32'(tx_pin), 32'd1);
    endtask

    initial begin : stimulus
        logic [9:0] lv;
        int         done_base;
        int         bad;

        reset_n  = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        #1 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        chk("rst_tx", 32'(tx_pin), 32'd1);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || wr_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_stable", 32'(bad), 32'd0);

        push_byte(8'h55);
        chk("b55_start_delay", 32'(tx_pin), 32'd1);
        chk("b55_count_after_push", 32'(fifo_count), 32'd1);
        @(negedge clk);
        frame_check("b55", 10'b1010101010, lv);

        push_byte(8'hA3);
        @(negedge clk);
        frame_check("ba3", 10'b1101000110, lv);
        chk("ba3_recovered", 32'(lv[8:1]), 32'hA3);

        done_base = done_cnt;
        fork
            begin : pusher
                int idx;
                int n;
                int drop;
                bit acc;
                bit saw_full;
                idx      = 0;
                n        = 0;
                drop     = 0;
                saw_full = 1'b0;
                wr_data  = 8'd1;
                wr_valid = 1'b1;
                while (idx < 6 && n < 40000) begin
                    if (!saw_full && fifo_count === 3'd4) begin
                        saw_full = 1'b1;
                        chk("full_ready_low", 32'(wr_ready), 32'd0);
                        drop    = 3;
                        wr_data = 8'hEE;
                    end
                    acc = (wr_ready === 1'b1);
                    @(negedge clk);
                    n++;
                    if (drop > 0) begin
                        chk("full_drop_count", 32'(fifo_count), 32'd4);
                        drop--;
                        if (drop == 0) wr_data = 8'(idx + 1);
                    end else if (acc) begin
                        idx++;
                        wr_data = 8'(idx + 1);
                    end
                end
                wr_valid = 1'b0;
                chk("full_seen", 32'(saw_full), 32'd1);
                chk("push_all", 32'(idx), 32'd6);
            end
            begin : receiver
                logic [7:0] b;
                longint     t0;
                longint     tprev;
                tprev = 0;
                for (int k = 0; k < 6; k++) begin
                    recv_byte(b, t0);
                    chk("seq_byte", 32'(b), 32'(k + 1));
                    if (k > 0) chk("seq_gap", 32'(t0 - tprev), 32'(FRAME));
                    tprev = t0;
                end
            end
        join
        repeat (CPB + 5) @(negedge clk);
        chk("six_done", 32'(done_cnt - done_base), 32'd6);
        chk("six_busy_after", 32'(busy), 32'd0);

        push_byte(8'hF0);
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (1000) @(negedge clk);
        chk("pre_reset_low", 32'(tx_pin), 32'd0);
        chk("pre_reset_count", 32'(fifo_count), 32'd2);
        done_base = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx_pin), 32'd1);
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        repeat (5000) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - done_base), 32'd0);
        chk("midrst_idle_tx", 32'(tx_pin), 32'd1);

        push_byte(8'h3C);
        chk("b3c_start_delay", 32'(tx_pin), 32'd1);
        @(negedge clk);
        frame_check("b3c", 10'b1001111000, lv);
        chk("b3c_recovered", 32'(lv[8:1]), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
